// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between two
// valid/ready requesters. One transaction in flight: IDLE -> EXEC -> RESP.
module alu_share_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    // requester 0
    input  logic              req_valid_0,
    output logic              req_ready_0,
    input  logic [WIDTH-1:0]  req_op1_0,
    input  logic [WIDTH-1:0]  req_op2_0,
    input  logic [CTRL_W-1:0] req_ctrl_0,
    output logic              rsp_valid_0,
    input  logic              rsp_ready_0,
    // requester 1
    input  logic              req_valid_1,
    output logic              req_ready_1,
    input  logic [WIDTH-1:0]  req_op1_1,
    input  logic [WIDTH-1:0]  req_op2_1,
    input  logic [CTRL_W-1:0] req_ctrl_1,
    output logic              rsp_valid_1,
    input  logic              rsp_ready_1,
    // shared response bus
    output logic [WIDTH-1:0]  rsp_result,
    output logic              rsp_zero,
    output logic              rsp_err,
    // shared ALU
    output logic [WIDTH-1:0]  alu_op1,
    output logic [WIDTH-1:0]  alu_op2,
    output logic [CTRL_W-1:0] alu_control,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_zero,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Control codes with this bit set are not valid ALU operations.
    localparam int ILLEGAL_BIT = 3;

    logic [1:0]        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_q, grant_d;
    logic [WIDTH-1:0]  op1_q, op1_d;
    logic [WIDTH-1:0]  op2_q, op2_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              zero_q, zero_d;
    logic              err_q, err_d;

    logic              grant_sel;
    logic              accept;
    logic              owner_rsp_ready;

    // Arbitration: a lone requester wins outright; on contention the one not served last wins.
    always_comb begin
        grant_sel = 1'b0;
        if (req_valid_0 && req_valid_1) begin
            grant_sel = ~last_grant_q;
        end else if (req_valid_1) begin
            grant_sel = 1'b1;
        end
        accept      = (state_q == ST_IDLE) && (req_valid_0 || req_valid_1) && !rst;
        req_ready_0 = accept && !grant_sel;
        req_ready_1 = accept && grant_sel;
    end

    // Next-state and datapath capture for the single in-flight transaction.
    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        grant_d         = grant_q;
        op1_d           = op1_q;
        op2_d           = op2_q;
        ctrl_d          = ctrl_q;
        result_d        = result_q;
        zero_d          = zero_q;
        err_d           = err_q;
        owner_rsp_ready = grant_q ? rsp_ready_1 : rsp_ready_0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    grant_d = grant_sel;
                    op1_d   = grant_sel ? req_op1_1  : req_op1_0;
                    op2_d   = grant_sel ? req_op2_1  : req_op2_0;
                    ctrl_d  = grant_sel ? req_ctrl_1 : req_ctrl_0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Illegal codes never reach the result bus; the ALU output is discarded.
                if (ctrl_q[ILLEGAL_BIT]) begin
                    result_d = '0;
                    zero_d   = 1'b1;
                    err_d    = 1'b1;
                end else begin
                    result_d = alu_result;
                    zero_d   = alu_zero;
                    err_d    = 1'b0;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                // Fairness pointer only moves once the owner has taken its result.
                if (owner_rsp_ready) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and response registers; reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
            err_q        <= err_d;
        end
    end

    // Latched operands; only observable while in EXEC, so no reset needed.
    always_ff @(posedge clk) begin
        op1_q  <= op1_d;
        op2_q  <= op2_d;
        ctrl_q <= ctrl_d;
    end

    // Output decode: ALU inputs are quiet outside EXEC; response routed to its owner.
    always_comb begin
        alu_op1     = (state_q == ST_EXEC) ? op1_q  : '0;
        alu_op2     = (state_q == ST_EXEC) ? op2_q  : '0;
        alu_control = (state_q == ST_EXEC) ? ctrl_q : '0;
        rsp_valid_0 = (state_q == ST_RESP) && !grant_q;
        rsp_valid_1 = (state_q == ST_RESP) && grant_q;
        rsp_result  = result_q;
        rsp_zero    = zero_q;
        rsp_err     = err_q;
        busy        = (state_q != ST_IDLE);
    end

endmodule
